// File: rtl/tns_link_pkg.sv
// Shared defaults and FSM state encodings for the TNS link scheduler.
package tns_link_pkg;

   localparam int DATA_W_DEF   = 6;
   localparam int SYM_MAX_DEF  = 36;
   localparam int HDR_BASE_DEF = 32;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_HDR   = 2'd1;
   localparam state_t ST_BURST = 2'd2;
   localparam state_t ST_GAP   = 2'd3;

endpackage

// File: rtl/tns_rr_arbiter.sv
// Pointer-based round-robin pick: first valid index at or after i_ptr, wrapping.
module tns_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   logic [IDX_W-1:0] w_cand;

   always_comb begin
      o_idx  = '0;
      w_cand = '0;
      // Scan farthest-first so the candidate nearest the pointer is written last.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
         if (i_valid[w_cand]) begin
            o_idx = w_cand;
         end
      end
   end

   assign o_any = |i_valid;

endmodule

// File: rtl/tns_link_scheduler.sv
// Round-robin scheduler sharing one TNS TSV link; each burst is preceded by an owner header.
module tns_link_scheduler
   import tns_link_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int SYM_MAX   = SYM_MAX_DEF,
   parameter int BURST_LEN = 8,
   parameter int HDR_BASE  = HDR_BASE_DEF,
   parameter int TIMEOUT   = 4,
   parameter int GAP_CYC   = 1
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic [NUM_REQ-1:0]          i_req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
   output logic [NUM_REQ-1:0]          o_req_ready,
   output logic [DATA_W-1:0]           o_enc_data,
   output logic                        o_enc_load,
   output logic [$clog2(NUM_REQ)-1:0]  o_cur_owner,
   output logic                        o_link_busy,
   output logic                        o_err_range
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int CNT_W  = $clog2(BURST_LEN + 1);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W  = $clog2(GAP_CYC + 1);

   if (HDR_BASE + NUM_REQ - 1 >= SYM_MAX) begin : g_bad_hdr
      $error("header symbols HDR_BASE..HDR_BASE+NUM_REQ-1 must lie below SYM_MAX");
   end

   state_t              r_state;
   logic [IDX_W-1:0]    r_owner;
   logic [IDX_W-1:0]    r_ptr;
   logic [CNT_W-1:0]    r_cnt;
   logic [IDLE_W-1:0]   r_idle;
   logic [GAP_W-1:0]    r_gap;
   logic [DATA_W-1:0]   r_enc_data;
   logic                r_enc_load;
   logic                r_err_range;

   logic [IDX_W-1:0]    w_pick;
   logic                w_any;
   logic [DATA_W-1:0]   w_sym;
   logic                w_sym_bad;
   logic                w_xfer;
   logic [IDLE_W-1:0]   w_idle_inc;
   logic [IDX_W-1:0]    w_ptr_nxt;
   logic [DATA_W-1:0]   w_hdr;

   tns_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .i_valid (i_req_valid),
      .i_ptr   (r_ptr),
      .o_idx   (w_pick),
      .o_any   (w_any)
   );

   assign w_sym      = i_req_data[int'(r_owner)*DATA_W +: DATA_W];
   assign w_sym_bad  = int'(w_sym) >= SYM_MAX;
   assign w_xfer     = (r_state == ST_BURST) && i_req_valid[r_owner];
   assign w_idle_inc = r_idle + IDLE_W'(1);
   assign w_ptr_nxt  = (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + IDX_W'(1);
   assign w_hdr      = DATA_W'(HDR_BASE + int'(r_owner));

   always_comb begin
      o_req_ready = '0;
      if (r_state == ST_BURST) begin
         o_req_ready[r_owner] = 1'b1;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_owner     <= '0;
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_idle      <= '0;
         r_gap       <= '0;
         r_enc_data  <= '0;
         r_enc_load  <= 1'b0;
         r_err_range <= 1'b0;
      end else begin
         r_err_range <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_enc_load <= 1'b0;
               if (w_any) begin
                  r_owner <= w_pick;
                  r_state <= ST_HDR;
               end
            end
            ST_HDR: begin
               r_enc_data <= w_hdr;
               r_enc_load <= 1'b1;
               r_cnt      <= '0;
               r_idle     <= '0;
               r_state    <= ST_BURST;
            end
            ST_BURST: begin
               if (w_xfer) begin
                  r_enc_load  <= 1'b1;
                  r_enc_data  <= w_sym_bad ? '0 : w_sym;
                  r_err_range <= w_sym_bad;
                  r_cnt       <= r_cnt + CNT_W'(1);
                  r_idle      <= '0;
                  if (r_cnt == CNT_W'(BURST_LEN - 1)) begin
                     r_state <= ST_GAP;
                     r_gap   <= '0;
                     r_ptr   <= w_ptr_nxt;
                  end
               end else begin
                  // Encoder holds its TSV state while no word is loaded.
                  r_enc_load <= 1'b0;
                  r_idle     <= w_idle_inc;
                  if (w_idle_inc == IDLE_W'(TIMEOUT)) begin
                     r_state <= ST_GAP;
                     r_gap   <= '0;
                     r_ptr   <= w_ptr_nxt;
                  end
               end
            end
            ST_GAP: begin
               r_enc_load <= 1'b0;
               if (r_gap == GAP_W'(GAP_CYC - 1)) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_gap <= r_gap + GAP_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_enc_data  = r_enc_data;
   assign o_enc_load  = r_enc_load;
   assign o_err_range = r_err_range;
   assign o_cur_owner = r_owner;
   assign o_link_busy = (r_state != ST_IDLE);

endmodule
